// File: rtl/mem_stage_pkg.sv
// Shared widths, load-FSM state encoding and the execute-to-memory bus layout
// for the memory-access stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 135;
  localparam int MS_TO_WS_BUS_WD = 134;
  localparam int MS_FWD_BUS_WD   = 71;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_HOLD = 2'd2
  } ms_state_e;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [63:0] alu_result;
    logic [63:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_buf.sv
// Load response tracker: waits for the data SRAM response and holds it while
// write-back is stalled, so a response is never dropped.
module mem_load_buf
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        accept_load,
  input  logic        fire,
  input  logic        rvalid,
  input  logic [63:0] rdata,
  output logic        data_ok,
  output logic [63:0] load_data
);

  ms_state_e   state;
  logic [63:0] rdata_r;

  // A response seen outside WAIT is a protocol error and simply ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= MS_IDLE;
      rdata_r <= '0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (accept_load) state <= MS_WAIT;
        end
        MS_WAIT: begin
          if (rvalid) begin
            if (fire) begin
              state <= accept_load ? MS_WAIT : MS_IDLE;
            end else begin
              rdata_r <= rdata;
              state   <= MS_HOLD;
            end
          end
        end
        MS_HOLD: begin
          if (fire) state <= accept_load ? MS_WAIT : MS_IDLE;
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

  assign data_ok   = (state == MS_HOLD) || ((state == MS_WAIT) && rvalid);
  assign load_data = (state == MS_HOLD) ? rdata_r : rdata;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: pipeline register, valid/allowin handshake, load result
// selection and the write-back / forwarding bus packing.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_rvalid,
  input  logic [63:0]                data_sram_rdata,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

  es_to_ms_t   es_in;
  es_to_ms_t   es_to_ms_bus_r;
  logic        ms_valid;
  logic        ms_ready_go;
  logic        accept;
  logic        accept_load;
  logic        fire;
  logic        data_ok;
  logic [63:0] load_data;
  logic [63:0] final_result;
  logic        fwd_valid;

  assign es_in       = es_to_ms_bus;
  assign accept      = es_to_ms_valid && ms_allowin;
  assign accept_load = accept && es_in.res_from_mem;
  assign fire        = ms_to_ws_valid && ws_allowin;

  // Stage input register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid       <= 1'b0;
      es_to_ms_bus_r <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (accept)     es_to_ms_bus_r <= es_in;
    end
  end

  // Gating with ms_valid keeps a stray response on an empty stage out of the FSM.
  mem_load_buf u_load_buf (
    .clk         (clk),
    .resetn      (resetn),
    .accept_load (accept_load),
    .fire        (fire),
    .rvalid      (data_sram_rvalid && ms_valid),
    .rdata       (data_sram_rdata),
    .data_ok     (data_ok),
    .load_data   (load_data)
  );

  assign ms_ready_go    = !es_to_ms_bus_r.res_from_mem || data_ok;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  assign final_result = es_to_ms_bus_r.res_from_mem ? load_data : es_to_ms_bus_r.alu_result;

  assign ms_to_ws_bus = {es_to_ms_bus_r.gr_we, es_to_ms_bus_r.dest,
                         final_result, es_to_ms_bus_r.pc};

  assign fwd_valid  = ms_valid && es_to_ms_bus_r.gr_we && (es_to_ms_bus_r.dest != 5'd0);
  assign ms_fwd_bus = {fwd_valid, ms_ready_go, es_to_ms_bus_r.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard: expected results are
// queued when an instruction is driven and compared when it leaves to write-back.
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [134:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [133:0] ms_to_ws_bus;
  logic         data_sram_rvalid;
  logic [63:0]  data_sram_rdata;
  logic [70:0]  ms_fwd_bus;

  int n_chk  = 0;
  int n_pass = 0;
  logic [133:0] exp_q[$];

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .data_sram_rvalid (data_sram_rvalid),
    .data_sram_rdata  (data_sram_rdata),
    .ms_fwd_bus       (ms_fwd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [4:0] dest, input logic [63:0] alu,
                       input logic [63:0] pc, input logic [63:0] res, input bit push);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = {ld, 1'b1, dest, alu, pc};
    if (push) exp_q.push_back({1'b1, dest, res, pc});
  endtask

  // Write-back side of the scoreboard
  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 134'(exp_q.size()), 134'd1);
      else chk("wb_bus", ms_to_ws_bus, exp_q.pop_front());
    end
  end

  initial begin
    resetn = 1'b0;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rvalid = 1'b0;
    data_sram_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", ms_to_ws_valid, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_fwd_vld", ms_fwd_bus[70], 0);
    chk("rst_bus", ms_to_ws_bus, '0);
    tick();
    resetn = 1'b1;
    tick();

    // Non-load pass-through
    drive(1'b0, 5'd5, 64'h1234, 64'h100, 64'h1234, 1);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("nl_vld", ms_to_ws_valid, 1);
    chk("nl_res", ms_to_ws_bus[127:64], 64'h1234);
    chk("nl_fwd_ok", ms_fwd_bus[69], 1);
    chk("nl_fwd_vld", ms_fwd_bus[70], 1);
    tick();

    // Load answered in its third cycle
    drive(1'b1, 5'd7, 64'hFFFF, 64'h200, 64'hDEAD_BEEF_0000_0001, 1);
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ld_allowin", ms_allowin, 0);
      chk("ld_fwd_ok", ms_fwd_bus[69], 0);
      chk("ld_vld", ms_to_ws_valid, 0);
      tick();
    end
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    chk("ld_vld_rsp", ms_to_ws_valid, 1);
    chk("ld_fwd_ok_rsp", ms_fwd_bus[69], 1);
    chk("ld_fwd_data", ms_fwd_bus[63:0], 64'hDEAD_BEEF_0000_0001);
    tick();
    data_sram_rvalid = 1'b0;
    data_sram_rdata  = '0;
    @(negedge clk);
    chk("ld_drained", ms_to_ws_valid, 0);
    tick();

    // Response arrives during a write-back stall
    ws_allowin = 1'b0;
    drive(1'b1, 5'd3, 64'h1, 64'h300, 64'h55AA, 1);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'h55AA;
    @(negedge clk);
    chk("hold_vld_rsp", ms_to_ws_valid, 1);
    tick();
    data_sram_rvalid = 1'b0;
    data_sram_rdata  = 64'hBAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_res", ms_to_ws_bus[127:64], 64'h55AA);
      chk("hold_vld", ms_to_ws_valid, 1);
      chk("hold_allowin", ms_allowin, 0);
      tick();
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("hold_fire_vld", ms_to_ws_valid, 1);
    tick();

    // Back-to-back loads, each answered in its first cycle
    drive(1'b1, 5'd9, 64'h0, 64'h400, 64'hA, 1);
    tick();
    drive(1'b1, 5'd10, 64'h0, 64'h408, 64'hB, 1);
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'hA;
    @(negedge clk);
    chk("b2b_vld_a", ms_to_ws_valid, 1);
    chk("b2b_allowin", ms_allowin, 1);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 64'hB;
    @(negedge clk);
    chk("b2b_vld_b", ms_to_ws_valid, 1);
    tick();
    data_sram_rvalid = 1'b0;

    // Spurious response with a non-load resident (dest 0: no forwarding)
    ws_allowin = 1'b0;
    drive(1'b0, 5'd0, 64'h77, 64'h500, 64'h77, 1);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'h999;
    @(negedge clk);
    chk("sp_res", ms_to_ws_bus[127:64], 64'h77);
    chk("sp_vld", ms_to_ws_valid, 1);
    chk("sp_fwd_vld", ms_fwd_bus[70], 0);
    tick();
    data_sram_rvalid = 1'b0;
    ws_allowin = 1'b1;
    @(negedge clk);
    tick();
    drive(1'b1, 5'd6, 64'h88, 64'h508, 64'hC, 1);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("sp_next_wait", ms_to_ws_valid, 0);
    tick();
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'hC;
    @(negedge clk);
    chk("sp_next_vld", ms_to_ws_valid, 1);
    tick();
    data_sram_rvalid = 1'b0;

    // Reset while a load is outstanding
    drive(1'b1, 5'd4, 64'h0, 64'h600, 64'h0, 0);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("rl_wait", ms_to_ws_valid, 0);
    #1 resetn = 1'b0;
    #1;
    chk("rl_vld", ms_to_ws_valid, 0);
    chk("rl_allowin", ms_allowin, 1);
    chk("rl_fwd_vld", ms_fwd_bus[70], 0);
    tick();
    resetn = 1'b1;
    tick();
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = 64'hE;
    @(negedge clk);
    chk("rl_late_rvalid", ms_to_ws_valid, 0);
    tick();
    data_sram_rvalid = 1'b0;
    tick();

    chk("sb_empty", 134'(exp_q.size()), 134'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
